// File: rtl/wb_byte_master_if.sv
// rtl/wb_byte_master_if.sv - byte-stream and Wishbone master signal bundle for wb_byte_master
interface wb_byte_master_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_we_o;
    logic [SELECT_WIDTH-1:0] wb_sel_o;
    logic                    wb_stb_o;
    logic                    wb_cyc_o;
    logic                    wb_ack_i;
    logic                    busy_o;

    modport master (
        input  in_data, in_valid, out_ready, wb_dat_i, wb_ack_i,
        output in_ready, out_data, out_valid, wb_adr_o, wb_dat_o,
               wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
    );

    modport slave (
        output in_data, in_valid, out_ready, wb_dat_i, wb_ack_i,
        input  in_ready, out_data, out_valid, wb_adr_o, wb_dat_o,
               wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
    );
endinterface

// File: rtl/wb_byte_master.sv
// rtl/wb_byte_master.sv - framed byte-stream to single-word Wishbone master bridge
module wb_byte_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    wb_byte_master_if.master bus
);
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WBUS, S_RBUS, S_RDATA, S_RESP, S_DRAIN
    } state_t;

    state_t                  r_state, r_state_n;
    logic                    r_write, r_write_n;
    logic [ADDR_WIDTH-1:0]   r_addr, r_addr_n;
    logic [7:0]              r_cnt, r_cnt_n;
    logic [7:0]              r_idx, r_idx_n;
    logic [DATA_WIDTH-1:0]   r_data, r_data_n;
    logic [TW-1:0]           r_tmo, r_tmo_n;
    logic [10:0]             r_drain, r_drain_n;
    logic [7:0]              r_out_data, r_out_data_n;
    logic                    r_out_valid, r_out_valid_n;
    logic                    r_cyc, r_cyc_n;
    logic                    r_stb, r_stb_n;
    logic                    r_we, r_we_n;
    logic [ADDR_WIDTH-1:0]   r_adr, r_adr_n;
    logic [DATA_WIDTH-1:0]   r_dat, r_dat_n;

    logic                    w_in_ready;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [ADDR_WIDTH-1:0]   w_addr_al;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [ADDR_WIDTH-1:0]   w_addr_shift;

    assign w_in_ready   = !rst && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_LEN ||
                                   r_state == S_WDATA || r_state == S_DRAIN);
    assign w_in_fire    = bus.in_valid && w_in_ready;
    assign w_out_fire   = r_out_valid && bus.out_ready;
    assign w_addr_al    = r_addr & ~ADDR_WIDTH'(SELECT_WIDTH - 1);
    assign w_addr_next  = w_addr_al + ADDR_WIDTH'(SELECT_WIDTH);
    // Shifting left drops address bits above ADDR_WIDTH as bytes arrive MSB first
    assign w_addr_shift = (r_addr << 8) | ADDR_WIDTH'(bus.in_data);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.wb_adr_o  = r_adr;
    assign bus.wb_dat_o  = r_dat;
    assign bus.wb_we_o   = r_we;
    assign bus.wb_sel_o  = '1;
    assign bus.wb_stb_o  = r_stb;
    assign bus.wb_cyc_o  = r_cyc;
    assign bus.busy_o    = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_tmo       <= '0;
            r_drain     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
        end else begin
            r_state     <= r_state_n;
            r_write     <= r_write_n;
            r_addr      <= r_addr_n;
            r_cnt       <= r_cnt_n;
            r_idx       <= r_idx_n;
            r_data      <= r_data_n;
            r_tmo       <= r_tmo_n;
            r_drain     <= r_drain_n;
            r_out_data  <= r_out_data_n;
            r_out_valid <= r_out_valid_n;
            r_cyc       <= r_cyc_n;
            r_stb       <= r_stb_n;
            r_we        <= r_we_n;
            r_adr       <= r_adr_n;
            r_dat       <= r_dat_n;
        end
    end

    always_comb begin
        r_state_n     = r_state;
        r_write_n     = r_write;
        r_addr_n      = r_addr;
        r_cnt_n       = r_cnt;
        r_idx_n       = r_idx;
        r_data_n      = r_data;
        r_tmo_n       = r_tmo;
        r_drain_n     = r_drain;
        r_out_data_n  = r_out_data;
        r_out_valid_n = r_out_valid;
        r_cyc_n       = r_cyc;
        r_stb_n       = r_stb;
        r_we_n        = r_we;
        r_adr_n       = r_adr;
        r_dat_n       = r_dat;

        case (r_state)
            S_IDLE: begin
                if (w_in_fire && (bus.in_data == 8'hA1 || bus.in_data == 8'hA2)) begin
                    r_write_n = (bus.in_data == 8'hA1);
                    r_addr_n  = '0;
                    r_idx_n   = '0;
                    r_state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_in_fire) begin
                    r_addr_n = w_addr_shift;
                    if (r_idx == 8'(ADDR_BYTES - 1)) begin
                        r_idx_n   = '0;
                        r_state_n = S_LEN;
                    end else begin
                        r_idx_n = r_idx + 8'd1;
                    end
                end
            end
            S_LEN: begin
                if (w_in_fire) begin
                    r_cnt_n = bus.in_data;
                    r_idx_n = '0;
                    if (r_write) begin
                        r_state_n = S_WDATA;
                    end else begin
                        r_cyc_n   = 1'b1;
                        r_stb_n   = 1'b1;
                        r_we_n    = 1'b0;
                        r_adr_n   = w_addr_al;
                        r_tmo_n   = '0;
                        r_state_n = S_RBUS;
                    end
                end
            end
            S_WDATA: begin
                if (w_in_fire) begin
                    r_data_n[int'(r_idx) * 8 +: 8] = bus.in_data;
                    if (r_idx == 8'(SELECT_WIDTH - 1)) begin
                        r_idx_n   = '0;
                        r_cyc_n   = 1'b1;
                        r_stb_n   = 1'b1;
                        r_we_n    = 1'b1;
                        r_adr_n   = w_addr_al;
                        r_dat_n   = r_data_n;
                        r_tmo_n   = '0;
                        r_state_n = S_WBUS;
                    end else begin
                        r_idx_n = r_idx + 8'd1;
                    end
                end
            end
            S_WBUS: begin
                if (bus.wb_ack_i) begin
                    r_cyc_n  = 1'b0;
                    r_stb_n  = 1'b0;
                    r_we_n   = 1'b0;
                    r_addr_n = w_addr_next;
                    if (r_cnt == 8'd0) begin
                        r_out_data_n  = 8'h5A;
                        r_out_valid_n = 1'b1;
                        r_state_n     = S_RESP;
                    end else begin
                        r_cnt_n   = r_cnt - 8'd1;
                        r_state_n = S_WDATA;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    r_cyc_n = 1'b0;
                    r_stb_n = 1'b0;
                    r_we_n  = 1'b0;
                    // Words after the one that timed out are still on the link
                    if (r_cnt != 8'd0) begin
                        r_drain_n = 11'(r_cnt) * 11'(SELECT_WIDTH);
                        r_state_n = S_DRAIN;
                    end else begin
                        r_out_data_n  = 8'hEE;
                        r_out_valid_n = 1'b1;
                        r_state_n     = S_RESP;
                    end
                end else begin
                    r_tmo_n = r_tmo + TW'(1);
                end
            end
            S_RBUS: begin
                if (bus.wb_ack_i) begin
                    r_cyc_n       = 1'b0;
                    r_stb_n       = 1'b0;
                    r_data_n      = bus.wb_dat_i;
                    r_addr_n      = w_addr_next;
                    r_idx_n       = '0;
                    r_out_data_n  = bus.wb_dat_i[7:0];
                    r_out_valid_n = 1'b1;
                    r_state_n     = S_RDATA;
                end else if (r_tmo == TMO_LAST) begin
                    r_cyc_n       = 1'b0;
                    r_stb_n       = 1'b0;
                    r_out_data_n  = 8'hEE;
                    r_out_valid_n = 1'b1;
                    r_state_n     = S_RESP;
                end else begin
                    r_tmo_n = r_tmo + TW'(1);
                end
            end
            S_RDATA: begin
                if (w_out_fire) begin
                    if (r_idx == 8'(SELECT_WIDTH - 1)) begin
                        r_out_valid_n = 1'b0;
                        r_idx_n       = '0;
                        if (r_cnt == 8'd0) begin
                            r_state_n = S_IDLE;
                        end else begin
                            r_cnt_n   = r_cnt - 8'd1;
                            r_cyc_n   = 1'b1;
                            r_stb_n   = 1'b1;
                            r_we_n    = 1'b0;
                            r_adr_n   = w_addr_al;
                            r_tmo_n   = '0;
                            r_state_n = S_RBUS;
                        end
                    end else begin
                        r_idx_n      = r_idx + 8'd1;
                        r_out_data_n = r_data[(int'(r_idx) + 1) * 8 +: 8];
                    end
                end
            end
            S_RESP: begin
                if (w_out_fire) begin
                    r_out_valid_n = 1'b0;
                    r_state_n     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_in_fire) begin
                    r_drain_n = r_drain - 11'd1;
                    if (r_drain == 11'd1) begin
                        r_out_data_n  = 8'hEE;
                        r_out_valid_n = 1'b1;
                        r_state_n     = S_RESP;
                    end
                end
            end
            default: r_state_n = S_IDLE;
        endcase
    end
endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Byte-stream to Wishbone master bridge; sits directly upstream of the Wishbone RAM and drives its slave port (adr/dat/we/sel/stb/cyc, ack).
- Decodes framed write/read commands from an 8-bit valid/ready stream (host link: UART/SPI front end) into single-word Wishbone cycles.
- Returns read data and write status on an 8-bit output stream.
- Used for program/data load and readback of on-chip memory.

Parameters:
- DATA_WIDTH, 32, Wishbone data width in bits (8, 16 or 32).
- ADDR_WIDTH, 16, Wishbone byte-address width; ADDR_BYTES = ceil(ADDR_WIDTH/8).
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT, 255, max cycles waiting for ack_i before abort (must be ≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  command/data byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  8  response byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  byte consumed when out_valid & out_ready.
- wb_adr_o  out  ADDR_WIDTH  byte address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  SELECT_WIDTH  byte select; always all ones.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  acknowledge.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock domain, clk; reset rst is synchronous, active-high.
- Reset (and rst asserted in any state):
  - state ← IDLE; in_ready=0; out_valid=0; out_data=0; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_adr_o=0; wb_dat_o=0; busy_o=0.
  - Any in-flight bus cycle is dropped in the same edge.
- Frame format: CMD, ADDR (ADDR_BYTES bytes, MSB first), LEN (word count = LEN+1, 1..256), then payload.
  - Write payload: (LEN+1)*SELECT_WIDTH bytes.
  - Word byte order is little-endian: the first byte of each word goes to dat[7:0].
  - CMD 0xA1 = write, 0xA2 = read. Any other CMD byte is consumed and ignored; state stays IDLE.
- in_ready=1 only in IDLE, ADDR, LEN, WDATA and DRAIN; 0 otherwise.
- States:
  - IDLE: accept CMD → ADDR.
  - ADDR: shift bytes into address register; after ADDR_BYTES bytes → LEN. Bits above ADDR_WIDTH are discarded. The low log2(SELECT_WIDTH) bits are cleared on use.
  - LEN: latch count → WDATA (write) or RBUS (read).
  - WDATA: assemble SELECT_WIDTH bytes; on last byte → WBUS with cyc=stb=we=1 from the next cycle.
  - WBUS: hold cyc/stb/adr/dat stable until wb_ack_i.
    - On the ack cycle, deassert cyc/stb on the next edge (no back-to-back strobe; the slave requires a gap).
    - Address += SELECT_WIDTH, wrapping modulo 2^ADDR_WIDTH.
    - Count exhausted → RESP(0x5A); else → WDATA.
  - RBUS: cyc=stb=1, we=0. On ack, capture wb_dat_i, drop cyc/stb, increment address → RDATA.
  - RDATA: present SELECT_WIDTH bytes LSB first, each held until out_ready.
    - After the last byte: count exhausted → IDLE; else → RBUS.
  - RESP: out_valid=1 with the status byte until out_ready → IDLE.
  - DRAIN: after a write timeout, consume and discard the remaining payload bytes without bus activity → RESP(0xEE).
- Timeout:
  - Counter starts at 0 on entering WBUS/RBUS and increments each cycle without ack.
  - Reaching TIMEOUT: drop cyc/stb on the next edge.
  - Write → DRAIN if payload bytes remain, else → RESP(0xEE).
  - Read → RESP(0xEE); remaining read bytes are not sent.
- Latency: minimum 2 cycles from strobe assertion to ack with zero-wait slave (ack registered).
- out_data and out_valid are registered; out_valid never drops without out_ready.

Test Plan:
- Write 1 word: bytes A1 00 10 00 EF BE AD DE, zero-wait RAM model → one WB write adr=0x0010, dat=0xDEADBEEF, sel=0xF; then out byte 0x5A; busy_o back to 0.
- Read 2 words after writing 0x11223344 @0x0010, 0x55667788 @0x0014: A2 00 10 01 → out 44 33 22 11 88 77 66 55; two WB reads; cyc low ≥1 cycle between them.
- Address wrap: write LEN=1 at 0xFFFC → second write at adr 0x0000; read back matches.
- Timeout: slave never acks, write A1 00 00 01 + 8 bytes → stb drops after 255 cycles; remaining 4 bytes drained with in_ready=1; out 0xEE; next frame works.
- Backpressure: read with out_ready toggling every other cycle → out_data stable while out_valid & !out_ready; byte order intact.
- Reset mid-read (rst during RBUS with stb=1) → next edge cyc/stb/out_valid=0, state IDLE; unknown CMD 0x55 then ignored, no bus activity.
